hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Produces the stall/flush control consumed by the D->E pipeline register. It also
//  freezes PC and the F->D register.
//  Keeps a shadow copy of the E and M stages (dest reg, Tnew) and compares it with
//  the Tuse of the instruction in D.
//  Adds a multiply/divide busy counter for HI/LO instructions. Sits beside the
//  decode stage of the 5-stage MIPS pipeline.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles started by mult/multu
//  DIV_CYCLES   10  busy cycles started by div/divu
//  CNT_W        4   width of MDU busy counter (must hold DIV_CYCLES)
// PORTS
//  clk       in   1   pipeline clock, rising edge
//  reset     in   1   asynchronous, active-high; clears all state
//  ir_d      in   32  instruction currently in D
//  stall     out  1   1 = hold F/D, insert bubble into D->E
//  pc_en     out  1   ~stall
//  fd_en     out  1   ~stall
//  de_clr    out  1   = stall (drives the D->E register's stall/clear input)
//  mdu_busy  out  1   MDU counter non-zero
//  stall_cnt out  32  total stall cycles (only with HAZ_STALL_STATS_EN)
// BEHAVIOUR
//  - Class of ir_d -> (a3, tnew_d, tuse_rs, tuse_rt); tuse 3 = "not read":
//    cal_r (addu/subu/and/or/slt/movz): a3=rd, tnew=1, tuse rs=1 rt=1
//    cal_i (ori/addiu/lui): a3=rt, tnew=1, tuse rs=1
//    load lw:  a3=rt, tnew=2, rs=1
//    store sw: a3=0, rs=1, rt=2
//    beq/bne: rs=0, rt=0
//    bgezal: rs=0, a3=31, tnew=0
//    jal: a3=31, tnew=0
//    jr/jalr: rs=0 (jalr also a3=rd, tnew=0)
//    mfhi/mflo: a3=rd, tnew=1
//    mthi/mtlo: rs=1
//    mult/div: rs=1, rt=1
//    anything else, including nop: a3=0
//  - Shadow regs {a3_e,tnew_e}, {a3_m,tnew_m}, each updated on the posedge:
//    E <= stall ? {0,0} : {a3, tnew_d}
//    M <= {a3_e, sat_dec(tnew_e)}; sat_dec(0)=0
//  - Data stall (combinational) for src in {rs, rt} with tuse != 3:
//    src != 0 && ((src == a3_e && tnew_e > tuse) || (src == a3_m && tnew_m > tuse))
//  - MDU start: mdu_start_e is set when a mult*/div* enters E (not stalled that cycle).
//    - Next edge: cnt <= MULT_CYCLES or DIV_CYCLES; otherwise decrement while non-zero.
//    - mdu_busy = (cnt != 0) || mdu_start_e.
//    - MDU stall = busy && D holds any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
//  - stall = data_stall | mdu_stall; all outputs are same-cycle combinational from
//    state + ir_d. Latency to release: 0 cycles after the hazard clears.
//  - Boundary rules:
//    - $0 never creates a hazard.
//    - Bubble inserted => E shadow a3=0.
//    - A new MDU start while cnt != 0 is impossible (it would have stalled).
//    - Counter reaching 0 and a waiting mfhi in D on the same cycle: no stall that cycle.
//  - Reset (any time, including mid-MDU operation):
//    - a3_e = a3_m = tnew_e = tnew_m = 0, cnt = 0, mdu_start_e = 0, stall_cnt = 0.
//    - Hence stall=0, pc_en=fd_en=1, de_clr=0, mdu_busy=0.
// CONFIGURATION
//  - HAZ_STALL_STATS_EN defined: 32-bit stall_cnt increments on every posedge with
//    stall=1 and wraps at 2^32.
//  - Undefined: the stall_cnt port and its register are absent.
// STRUCTURE
//  - Shared package mips_pipe_pkg:
//    - opcode/funct localparams
//    - TUSE_NONE=3
//    - TNEW_* constants
//    - instruction-class codes (CAL_R, CAL_I, LOAD, STORE, BRANCH, JUMP_LINK, MDU_*)
//  - One sub-module, instr_class_decode (combinational): ir -> a3, tnew, tuse_rs,
//    tuse_rt, is_mdu_start, is_mdu_use.
//  - Top holds the shadow regs, MDU counter, stall logic and optional stats.
// TESTING
//  1. lw $1,0($0) in E, then addu $2,$1,$3 in D -> stall=1 for 1 cycle (tnew_e=2>1);
//     next cycle M tnew=1, stall=0.
//  2. lw $1 in E, beq $1,$2 in D -> stall 2 cycles (E: 2>0, M: 1>0), then stall=0.
//  3. ori $5,$0,1 in E, sw $5,0($0) in D -> no stall (tnew 1 <= tuse_rt 2);
//     same with dest $0 plus any reader -> no stall.
//  4. mult $1,$2 issued, mflo $3 in D next -> stall for 6 cycles (start + 5),
//     released on the cycle cnt hits 0; div gives 11.
//  5. Assert reset mid-div (cnt=7) -> mdu_busy, stall, and cnt drop to 0 immediately
//     (async); mflo in D after reset -> no stall.
//  6. With HAZ_STALL_STATS_EN, run test 4 -> stall_cnt=6; without it, stall_cnt is
//     not elaborated.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Definitions shared by the decode-side hazard logic of the 5-stage MIPS pipeline.
// Contents:
//   - opcode / funct / REGIMM-rt field encodings
//   - Tuse / Tnew encodings (TUSE_NONE = operand not read)
//   - instruction class codes produced by instr_class_decode
//   - sat_dec(): saturating decrement used when Tnew ages one stage
// Configuration macro used elsewhere in this slice: HAZ_STALL_STATS_EN.
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

    // Primary opcodes (ir[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes (ir[5:0])
    localparam logic [5:0] FN_MOVZ  = 6'h0A;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // REGIMM rt field selecting bgezal
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    // Link register written by jal / bgezal
    localparam logic [4:0] REG_RA = 5'd31;

    // Tuse: stage distance (from D) at which an operand is first needed
    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew: cycles (counted from the E stage) until the result is forwardable
    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_CAL_R,
        CLS_CAL_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_BRANCH_LINK,
        CLS_JUMP_LINK,
        CLS_JUMP_REG,
        CLS_JUMP_REG_LINK,
        CLS_MDU_START,
        CLS_MDU_MF,
        CLS_MDU_MT
    } instr_class_e;

    // Tnew ages by one per stage but never goes below zero
    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        if (t == 2'd0) begin
            return 2'd0;
        end
        return t - 2'd1;
    endfunction

endpackage : mips_pipe_pkg

// File: rtl/instr_class_decode.sv
// -----------------------------------------------------------------------------
// instr_class_decode
// Purely combinational classification of the instruction held in D into the
// attributes the hazard unit needs.
// Ports:
//   ir_i            in  32  instruction word
//   a3_o            out 5   destination register (0 = writes nothing)
//   tnew_o          out 2   Tnew as seen when the instruction sits in E
//   tuse_rs_o       out 2   Tuse of rs (TUSE_NONE = not read)
//   tuse_rt_o       out 2   Tuse of rt (TUSE_NONE = not read)
//   is_mdu_start_o  out 1   mult/multu/div/divu
//   is_mdu_div_o    out 1   div/divu (selects the long busy period)
//   is_mdu_use_o    out 1   any HI/LO instruction (must wait for the MDU)
// -----------------------------------------------------------------------------
module instr_class_decode
    import mips_pipe_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [4:0]  a3_o,
    output logic [1:0]  tnew_o,
    output logic [1:0]  tuse_rs_o,
    output logic [1:0]  tuse_rt_o,
    output logic        is_mdu_start_o,
    output logic        is_mdu_div_o,
    output logic        is_mdu_use_o
);

    logic [5:0]   opcode;
    logic [5:0]   funct;
    logic [4:0]   rt;
    logic [4:0]   rd;
    instr_class_e cls;

    assign opcode = ir_i[31:26];
    assign rt     = ir_i[20:16];
    assign rd     = ir_i[15:11];
    assign funct  = ir_i[5:0];

    // rs and shamt fields do not influence the classification
    logic unused_fields;
    assign unused_fields = ^{ir_i[25:21], ir_i[10:6]};

    always_comb begin
        cls = CLS_NONE;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_AND,
                    FN_OR, FN_SLT, FN_MOVZ:            cls = CLS_CAL_R;
                    FN_JR:                             cls = CLS_JUMP_REG;
                    FN_JALR:                           cls = CLS_JUMP_REG_LINK;
                    FN_MFHI, FN_MFLO:                  cls = CLS_MDU_MF;
                    FN_MTHI, FN_MTLO:                  cls = CLS_MDU_MT;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: cls = CLS_MDU_START;
                    default:                           cls = CLS_NONE;
                endcase
            end
            OP_REGIMM: begin
                if (rt == RT_BGEZAL) begin
                    cls = CLS_BRANCH_LINK;
                end
            end
            OP_JAL:                   cls = CLS_JUMP_LINK;
            OP_BEQ, OP_BNE:           cls = CLS_BRANCH;
            OP_ORI, OP_ADDIU, OP_LUI: cls = CLS_CAL_I;
            OP_LW:                    cls = CLS_LOAD;
            OP_SW:                    cls = CLS_STORE;
            default:                  cls = CLS_NONE;
        endcase
    end

    always_comb begin
        a3_o           = 5'd0;
        tnew_o         = TNEW_0;
        tuse_rs_o      = TUSE_NONE;
        tuse_rt_o      = TUSE_NONE;
        is_mdu_start_o = 1'b0;
        is_mdu_use_o   = 1'b0;
        case (cls)
            CLS_CAL_R: begin
                a3_o      = rd;
                tnew_o    = TNEW_1;
                tuse_rs_o = TUSE_1;
                tuse_rt_o = TUSE_1;
            end
            CLS_CAL_I: begin
                a3_o      = rt;
                tnew_o    = TNEW_1;
                tuse_rs_o = TUSE_1;
            end
            CLS_LOAD: begin
                a3_o      = rt;
                tnew_o    = TNEW_2;
                tuse_rs_o = TUSE_1;
            end
            CLS_STORE: begin
                // store data is only needed in M
                tuse_rs_o = TUSE_1;
                tuse_rt_o = TUSE_2;
            end
            CLS_BRANCH: begin
                tuse_rs_o = TUSE_0;
                tuse_rt_o = TUSE_0;
            end
            CLS_BRANCH_LINK: begin
                a3_o      = REG_RA;
                tnew_o    = TNEW_0;
                tuse_rs_o = TUSE_0;
            end
            CLS_JUMP_LINK: begin
                a3_o   = REG_RA;
                tnew_o = TNEW_0;
            end
            CLS_JUMP_REG: begin
                tuse_rs_o = TUSE_0;
            end
            CLS_JUMP_REG_LINK: begin
                a3_o      = rd;
                tnew_o    = TNEW_0;
                tuse_rs_o = TUSE_0;
            end
            CLS_MDU_MF: begin
                a3_o         = rd;
                tnew_o       = TNEW_1;
                is_mdu_use_o = 1'b1;
            end
            CLS_MDU_MT: begin
                tuse_rs_o    = TUSE_1;
                is_mdu_use_o = 1'b1;
            end
            CLS_MDU_START: begin
                tuse_rs_o      = TUSE_1;
                tuse_rt_o      = TUSE_1;
                is_mdu_start_o = 1'b1;
                is_mdu_use_o   = 1'b1;
            end
            default: begin
                a3_o = 5'd0;
            end
        endcase
    end

    assign is_mdu_div_o = (cls == CLS_MDU_START) &&
                          ((funct == FN_DIV) || (funct == FN_DIVU));

endmodule : instr_class_decode

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Decode-stage stall/flush controller for the 5-stage MIPS pipeline. Keeps a
// shadow of the destination register and Tnew of the E and M stages, compares
// them against the Tuse of the instruction in D, and tracks the multiply/divide
// unit busy period so that HI/LO instructions wait for it.
// Parameters:
//   MULT_CYCLES  busy cycles started by mult/multu
//   DIV_CYCLES   busy cycles started by div/divu
//   CNT_W        busy counter width; must be able to hold DIV_CYCLES
// Ports:
//   clk        in  1   pipeline clock, rising edge
//   reset      in  1   asynchronous active-high, clears all state
//   ir_d       in  32  instruction currently in D
//   stall      out 1   hold F/D and insert a bubble into D->E
//   pc_en      out 1   ~stall
//   fd_en      out 1   ~stall
//   de_clr     out 1   = stall
//   mdu_busy   out 1   MDU busy (counter non-zero or start in E)
//   stall_cnt  out 32  stall cycle count, present only with HAZ_STALL_STATS_EN
// Configuration: define HAZ_STALL_STATS_EN to add the stall_cnt statistics.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_d,
    output logic        stall,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_clr,
    output logic        mdu_busy
`ifdef HAZ_STALL_STATS_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    // ------------------------------------------------------------------
    // Decode of the instruction in D
    // ------------------------------------------------------------------
    logic [4:0] a3_dec;
    logic [1:0] tnew_dec;
    logic [1:0] tuse_rs_dec;
    logic [1:0] tuse_rt_dec;
    logic       mdu_start_dec;
    logic       mdu_div_dec;
    logic       mdu_use_dec;

    instr_class_decode u_decode (
        .ir_i           (ir_d),
        .a3_o           (a3_dec),
        .tnew_o         (tnew_dec),
        .tuse_rs_o      (tuse_rs_dec),
        .tuse_rt_o      (tuse_rt_dec),
        .is_mdu_start_o (mdu_start_dec),
        .is_mdu_div_o   (mdu_div_dec),
        .is_mdu_use_o   (mdu_use_dec)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]       a3_e_q, a3_e_d;
    logic [1:0]       tnew_e_q, tnew_e_d;
    logic [4:0]       a3_m_q, a3_m_d;
    logic [1:0]       tnew_m_q, tnew_m_d;
    logic             mdu_start_e_q, mdu_start_e_d;
    logic             mdu_div_e_q, mdu_div_e_d;
    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;

    // ------------------------------------------------------------------
    // Data hazard: one comparator pair per source operand (0 = rs, 1 = rt)
    // ------------------------------------------------------------------
    logic [4:0] src_reg  [2];
    logic [1:0] src_tuse [2];
    logic [1:0] src_hazard;

    assign src_reg[0]  = ir_d[25:21];
    assign src_reg[1]  = ir_d[20:16];
    assign src_tuse[0] = tuse_rs_dec;
    assign src_tuse[1] = tuse_rt_dec;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            // $0 is hard-wired, so a producer targeting it is never waited on
            assign src_hazard[gi] = (src_tuse[gi] != TUSE_NONE) &&
                                    (src_reg[gi] != 5'd0) &&
                                    (((src_reg[gi] == a3_e_q) && (tnew_e_q > src_tuse[gi])) ||
                                     ((src_reg[gi] == a3_m_q) && (tnew_m_q > src_tuse[gi])));
        end
    endgenerate

    logic data_stall;
    logic mdu_stall;

    assign data_stall = |src_hazard;

    // A start sitting in E counts as busy before the counter has been loaded,
    // so a HI/LO reader right behind a mult/div is held from the first cycle.
    assign mdu_busy  = (mdu_cnt_q != '0) || mdu_start_e_q;
    assign mdu_stall = mdu_busy && mdu_use_dec;

    assign stall  = data_stall | mdu_stall;
    assign pc_en  = ~stall;
    assign fd_en  = ~stall;
    assign de_clr = stall;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        a3_e_d        = a3_dec;
        tnew_e_d      = tnew_dec;
        mdu_start_e_d = mdu_start_dec;
        mdu_div_e_d   = mdu_div_dec;
        if (stall) begin
            // bubble into E: nothing written, no MDU start
            a3_e_d        = 5'd0;
            tnew_e_d      = TNEW_0;
            mdu_start_e_d = 1'b0;
            mdu_div_e_d   = 1'b0;
        end

        a3_m_d   = a3_e_q;
        tnew_m_d = sat_dec(tnew_e_q);

        if (mdu_start_e_q) begin
            mdu_cnt_d = mdu_div_e_q ? DIV_LOAD : MULT_LOAD;
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
        end else begin
            mdu_cnt_d = mdu_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a3_e_q        <= 5'd0;
            tnew_e_q      <= TNEW_0;
            a3_m_q        <= 5'd0;
            tnew_m_q      <= TNEW_0;
            mdu_start_e_q <= 1'b0;
            mdu_div_e_q   <= 1'b0;
            mdu_cnt_q     <= '0;
        end else begin
            a3_e_q        <= a3_e_d;
            tnew_e_q      <= tnew_e_d;
            a3_m_q        <= a3_m_d;
            tnew_m_q      <= tnew_m_d;
            mdu_start_e_q <= mdu_start_e_d;
            mdu_div_e_q   <= mdu_div_e_d;
            mdu_cnt_q     <= mdu_cnt_d;
        end
    end

`ifdef HAZ_STALL_STATS_EN
    // ------------------------------------------------------------------
    // Stall statistics, wraps at 2^32
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed bench for hazard_stall_ctrl. Inputs change just after the falling
// edge and outputs are checked 1 ns later, well away from the rising edge.
// Expected values are hand-derived from the pipeline hazard rules.
// Define HAZ_STALL_STATS_EN to also check the stall_cnt statistics.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] ir_d;
    logic        stall;
    logic        pc_en;
    logic        fd_en;
    logic        de_clr;
    logic        mdu_busy;
`ifdef HAZ_STALL_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] sc_base;
`endif

    int vectors     = 0;
    int miscompares = 0;

    hazard_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ir_d      (ir_d),
        .stall     (stall),
        .pc_en     (pc_en),
        .fd_en     (fd_en),
        .de_clr    (de_clr),
        .mdu_busy  (mdu_busy)
`ifdef HAZ_STALL_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction encoders
    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks every control output against the expected stall / busy state
    task automatic chk(input string tag, input logic exp_stall, input logic exp_busy);
        check({tag, "/stall"},    {31'd0, stall},    {31'd0, exp_stall});
        check({tag, "/pc_en"},    {31'd0, pc_en},    {31'd0, ~exp_stall});
        check({tag, "/fd_en"},    {31'd0, fd_en},    {31'd0, ~exp_stall});
        check({tag, "/de_clr"},   {31'd0, de_clr},   {31'd0, exp_stall});
        check({tag, "/mdu_busy"}, {31'd0, mdu_busy}, {31'd0, exp_busy});
        $display("step %-14s ir_d=%08h stall=%0b mdu_busy=%0b", tag, ir_d, stall, mdu_busy);
    endtask

    // Present a new instruction in D for one cycle
    task automatic cyc(input logic [31:0] ir);
        @(negedge clk);
        ir_d = ir;
        #1;
    endtask

    logic [31:0] NOP, LW1, ADDU_RS1, ADDU_RT1, BEQ12, ORI5, SW5, LW0, BEQ00;
    logic [31:0] JAL, JR31, MFHI7, BEQ70, MULT12, MFLO3, DIV12, MFHI4;

    initial begin
        NOP      = 32'd0;
        LW1      = itype(6'h23, 5'd0, 5'd1, 16'd0);
        ADDU_RS1 = rtype(5'd1, 5'd3, 5'd2, 6'h21);
        ADDU_RT1 = rtype(5'd3, 5'd1, 5'd2, 6'h21);
        BEQ12    = itype(6'h04, 5'd1, 5'd2, 16'd4);
        ORI5     = itype(6'h0D, 5'd0, 5'd5, 16'd1);
        SW5      = itype(6'h2B, 5'd0, 5'd5, 16'd0);
        LW0      = itype(6'h23, 5'd0, 5'd0, 16'd0);
        BEQ00    = itype(6'h04, 5'd0, 5'd0, 16'd4);
        JAL      = {6'h03, 26'd16};
        JR31     = rtype(5'd31, 5'd0, 5'd0, 6'h08);
        MFHI7    = rtype(5'd0, 5'd0, 5'd7, 6'h10);
        BEQ70    = itype(6'h04, 5'd7, 5'd0, 16'd4);
        MULT12   = rtype(5'd1, 5'd2, 5'd0, 6'h18);
        MFLO3    = rtype(5'd0, 5'd0, 5'd3, 6'h12);
        DIV12    = rtype(5'd1, 5'd2, 5'd0, 6'h1A);
        MFHI4    = rtype(5'd0, 5'd0, 5'd4, 6'h10);

        // Reset state
        reset = 1'b1;
        ir_d  = NOP;
        #2;
        chk("reset", 1'b0, 1'b0);
`ifdef HAZ_STALL_STATS_EN
        check("reset/stall_cnt", stall_cnt, 32'd0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // lw -> addu reading rs: one stall, then released by M tnew=1
        cyc(LW1);      chk("t1_lw", 1'b0, 1'b0);
        cyc(ADDU_RS1); chk("t1_addu_e", 1'b1, 1'b0);
        cyc(ADDU_RS1); chk("t1_addu_m", 1'b0, 1'b0);
        cyc(NOP);      chk("t1_nop", 1'b0, 1'b0);
        cyc(NOP);

        // same through rt
        cyc(LW1);      chk("t1r_lw", 1'b0, 1'b0);
        cyc(ADDU_RT1); chk("t1r_addu_e", 1'b1, 1'b0);
        cyc(ADDU_RT1); chk("t1r_addu_m", 1'b0, 1'b0);
        cyc(NOP);
        cyc(NOP);

        // lw -> beq: two stalls (E 2>0, M 1>0)
        cyc(LW1);   chk("t2_lw", 1'b0, 1'b0);
        cyc(BEQ12); chk("t2_beq_e", 1'b1, 1'b0);
        cyc(BEQ12); chk("t2_beq_m", 1'b1, 1'b0);
        cyc(BEQ12); chk("t2_beq_go", 1'b0, 1'b0);
        cyc(NOP);
        cyc(NOP);

        // ori -> sw data: tnew 1 <= tuse_rt 2, no stall; $0 never hazards
        cyc(ORI5);  chk("t3_ori", 1'b0, 1'b0);
        cyc(SW5);   chk("t3_sw", 1'b0, 1'b0);
        cyc(LW0);   chk("t3_lw0", 1'b0, 1'b0);
        cyc(BEQ00); chk("t3_beq0", 1'b0, 1'b0);
        cyc(NOP);

        // jal (tnew 0) -> jr $31 (tuse 0): no stall
        cyc(JAL);   chk("jal", 1'b0, 1'b0);
        cyc(JR31);  chk("jr31", 1'b0, 1'b0);
        // mfhi (tnew 1) -> beq (tuse 0): one stall
        cyc(MFHI7); chk("mfhi7", 1'b0, 1'b0);
        cyc(BEQ70); chk("beq7_e", 1'b1, 1'b0);
        cyc(BEQ70); chk("beq7_m", 1'b0, 1'b0);
        cyc(NOP);
        cyc(NOP);

        // mult then mflo: 6 stall cycles, released when counter reaches 0
        cyc(MULT12); chk("t4_mult", 1'b0, 1'b0);
`ifdef HAZ_STALL_STATS_EN
        sc_base = stall_cnt;
`endif
        for (int i = 0; i < 6; i++) begin
            cyc(MFLO3); chk($sformatf("t4_mflo%0d", i), 1'b1, 1'b1);
        end
        cyc(MFLO3); chk("t4_mflo_go", 1'b0, 1'b0);
`ifdef HAZ_STALL_STATS_EN
        check("t6_stall_cnt", stall_cnt - sc_base, 32'd6);
`endif
        cyc(NOP);

        // div then mfhi: 11 stall cycles
        cyc(DIV12); chk("t4_div", 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            cyc(MFHI4); chk($sformatf("t4_mfhi%0d", i), 1'b1, 1'b1);
        end
        cyc(MFHI4); chk("t4_mfhi_go", 1'b0, 1'b0);
        cyc(NOP);

        // asynchronous reset while the divide counter holds 7
        cyc(DIV12); chk("t5_div", 1'b0, 1'b0);
        cyc(MFLO3); chk("t5_start", 1'b1, 1'b1);
        cyc(MFLO3); chk("t5_cnt10", 1'b1, 1'b1);
        cyc(MFLO3); chk("t5_cnt9", 1'b1, 1'b1);
        cyc(MFLO3); chk("t5_cnt8", 1'b1, 1'b1);
        cyc(MFLO3); chk("t5_cnt7", 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        chk("t5_rst", 1'b0, 1'b0);
`ifdef HAZ_STALL_STATS_EN
        check("t5_rst/stall_cnt", stall_cnt, 32'd0);
`endif
        #1;
        reset = 1'b0;
        #1;
        chk("t5_rel", 1'b0, 1'b0);
        cyc(MFLO3); chk("t5_mflo", 1'b0, 1'b0);
        cyc(NOP);   chk("t5_nop", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_hazard_stall_ctrl
